// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters with registered active/sync/frame-strobe decodes
module vga_timing_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active,
  output logic       hsync,
  output logic       vsync,
  output logic       next_frame,
  output logic [7:0] frame_count
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  logic [9:0] nx, ny;
  logic       nf;
  // next raster position; decodes below are taken from it so they line up with x/y
  always_comb begin
    nx = !pix_en ? x : (x == H_LAST) ? '0 : x + 10'd1;
    ny = (!pix_en || x != H_LAST) ? y : (y == V_LAST) ? '0 : y + 10'd1;
    nf = pix_en && x == H_LAST && ny == V_ACT;
  end
  // counter and decode registers; reset parks at the last pixel so the first advance lands on (0,0)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x           <= H_LAST;
      y           <= V_LAST;
      active      <= 1'b0;
      hsync       <= ~SYNC_ACTIVE;
      vsync       <= ~SYNC_ACTIVE;
      next_frame  <= 1'b0;
      frame_count <= '0;
    end else begin
      x           <= nx;
      y           <= ny;
      active      <= nx < H_ACT && ny < V_ACT;
      hsync       <= (nx >= HS_BEG && nx < HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync       <= (ny >= VS_BEG && ny < VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      next_frame  <= nf;
      frame_count <= frame_count + {7'd0, nf};
    end
  end
endmodule
